// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the instruction memory loader
package loader_pkg;

    typedef enum logic [1:0] {
        HDR0 = 2'd0,
        HDR1 = 2'd1,
        DATA = 2'd2,
        RUN  = 2'd3
    } load_state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int DEPTH_DEFAULT  = 64;

endpackage

// File: rtl/instr_ram.sv
// rtl/instr_ram.sv - DEPTH x 32 instruction RAM, synchronous write, asynchronous read
module instr_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - fills instruction memory from a byte stream and holds the core in reset until done
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic        load_req,
    input  logic [31:0] PC,
    output logic [31:0] Instr,
    output logic        cpu_reset,
    output logic        loading,
    output logic        load_err
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [16:0] DEPTH17   = 17'(DEPTH);
    localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    load_state_t state;
    logic [7:0]  n_lo;
    logic [15:0] n_words;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] partial;

    logic        xfer;
    logic        word_done;
    logic        we;
    logic [31:0] wdata;
    logic        unused_pc;

    assign byte_ready = (state != RUN);
    assign loading    = (state != RUN);
    assign cpu_reset  = reset | (state != RUN);

    assign xfer      = byte_valid && byte_ready;
    assign word_done = xfer && (state == DATA) && (byte_cnt == LAST_BYTE);
    // Words beyond the memory are still counted but never written, so they cannot alias low addresses.
    assign we        = word_done && ({1'b0, word_idx} < DEPTH17) && !reset && !load_req;
    assign wdata     = {byte_in, partial};

    // Fetch ignores the byte offset and wraps upper address bits.
    assign unused_pc = ^{PC[31:AW+2], PC[1:0]};

    always_ff @(posedge clk) begin
        if (reset || load_req) begin
            state    <= HDR0;
            n_lo     <= 8'd0;
            n_words  <= 16'd0;
            word_idx <= 16'd0;
            byte_cnt <= 2'd0;
            partial  <= 24'd0;
            load_err <= 1'b0;
        end else if (xfer) begin
            case (state)
                HDR0: begin
                    n_lo  <= byte_in;
                    state <= HDR1;
                end
                HDR1: begin
                    n_words  <= {byte_in, n_lo};
                    load_err <= ({1'b0, byte_in, n_lo} > DEPTH17);
                    state    <= ({byte_in, n_lo} == 16'd0) ? RUN : DATA;
                end
                DATA: begin
                    // Little-endian: earlier bytes shift toward the low end.
                    partial  <= {byte_in, partial[23:8]};
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == LAST_BYTE) begin
                        word_idx <= word_idx + 16'd1;
                        if (word_idx == n_words - 16'd1) begin
                            state <= RUN;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    instr_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (word_idx[AW-1:0]),
        .wdata (wdata),
        .raddr (PC[AW+1:2]),
        .rdata (Instr)
    );

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - randomized self-checking bench for instr_mem_loader
module tb_instr_mem_loader;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        load_req = 1'b0;
    logic [31:0] PC = 32'd0;
    logic [31:0] Instr;
    logic        cpu_reset;
    logic        loading;
    logic        load_err;

    always #5 clk = ~clk;

    instr_mem_loader #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .load_req   (load_req),
        .PC         (PC),
        .Instr      (Instr),
        .cpu_reset  (cpu_reset),
        .loading    (loading),
        .load_err   (load_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model_mem [DEPTH];
    bit          known [DEPTH];
    logic [31:0] img [$];
    logic [7:0]  stream [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rand_image(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom);
    endtask

    task automatic build_stream(input int n);
        stream.delete();
        stream.push_back(n[7:0]);
        stream.push_back(n[15:8]);
        foreach (img[i]) begin
            for (int b = 0; b < 4; b++) stream.push_back(8'(img[i] >> (8 * b)));
        end
    endtask

    // Reference: completed words land at their index if it fits, everything else is dropped.
    task automatic commit_words(input int count);
        for (int i = 0; i < count; i++) begin
            if (i < DEPTH) begin
                model_mem[i] = img[i];
                known[i]     = 1'b1;
            end
        end
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            if (known[i]) begin
                PC = 32'(i) << 2;
                #1;
                check(tag, Instr, model_mem[i]);
            end
        end
    endtask

    task automatic push(input bit gaps, output int cycles);
        int  i;
        int  guard;
        bit  acc;
        i = 0; guard = 0; cycles = 0;
        while (i < stream.size() && guard < 5000) begin
            @(negedge clk);
            byte_valid = !gaps || (cycles % 2 == 0);
            byte_in    = stream[i];
            acc        = byte_valid && byte_ready;
            @(posedge clk);
            if (acc) i++;
            cycles++;
            guard++;
        end
        @(negedge clk);
        byte_valid = 1'b0;
        check("bytes_consumed", 32'(i), 32'(stream.size()));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_byte_ready"}, 32'(byte_ready), 32'd1);
        check({tag, "_cpu_reset"},  32'(cpu_reset),  32'd1);
        check({tag, "_loading"},    32'(loading),    32'd1);
        check({tag, "_load_err"},   32'(load_err),   32'd0);
    endtask

    task automatic check_run(input string tag, input logic err);
        check({tag, "_cpu_reset"},  32'(cpu_reset),  32'd0);
        check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_loading"},    32'(loading),    32'd0);
        check({tag, "_load_err"},   32'(load_err),   32'(err));
    endtask

    initial begin
        int cyc;
        int n;
        logic [31:0] pc_r;

        foreach (known[i]) known[i] = 1'b0;

        // Reset state
        do_reset();
        check_idle("reset");

        // N = 2, back-to-back
        img.delete();
        img.push_back(32'hE3A00005);
        img.push_back(32'hE2801001);
        build_stream(2);
        push(1'b0, cyc);
        check("n2_cycles", 32'(cyc), 32'd10);
        check_run("n2", 1'b0);
        commit_words(2);
        PC = 32'd0; #1; check("n2_pc0", Instr, 32'hE3A00005);
        PC = 32'd4; #1; check("n2_pc4", Instr, 32'hE2801001);

        // Reset asserted while running drives cpu_reset immediately
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_comb_cpu_reset", 32'(cpu_reset), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_idle("reset2");

        // N = DEPTH + 1: overflow flagged, extra word dropped
        rand_image(DEPTH + 1);
        build_stream(DEPTH + 1);
        push(1'b0, cyc);
        check("ovf_cycles", 32'(cyc), 32'(2 + 4 * (DEPTH + 1)));
        check_run("ovf", 1'b1);
        commit_words(DEPTH + 1);
        check_mem("ovf_mem");

        // load_req while running restarts and clears load_err
        @(negedge clk);
        load_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_req = 1'b0;
        check_idle("load_req");

        // N = 2 with byte_valid toggling; words above 1 keep prior contents
        img.delete();
        img.push_back(32'hE3A00005);
        img.push_back(32'hE2801001);
        build_stream(2);
        push(1'b1, cyc);
        check("gap_cycles", 32'(cyc), 32'd19);
        check_run("gap", 1'b0);
        commit_words(2);
        check_mem("gap_mem");

        // Bytes offered in RUN are ignored
        @(negedge clk);
        byte_valid = 1'b1;
        repeat (6) begin
            byte_in = 8'($urandom);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        check_run("run_ignore", 1'b0);
        check_mem("run_ignore_mem");

        // N = 0: RUN two cycles after reset, memory untouched
        do_reset();
        img.delete();
        build_stream(0);
        push(1'b0, cyc);
        check("n0_cycles", 32'(cyc), 32'd2);
        check_run("n0", 1'b0);
        check_mem("n0_mem");

        // Reset after 5 data bytes: word 0 lands, partial word 1 is discarded
        do_reset();
        rand_image(10);
        build_stream(10);
        while (stream.size() > 7) void'(stream.pop_back());
        push(1'b0, cyc);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_cpu_reset", 32'(cpu_reset), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_idle("abort");
        commit_words(1);
        check_mem("abort_mem");

        // Fresh random image after the abort
        n = $urandom_range(DEPTH, 4);
        rand_image(n);
        build_stream(n);
        push(1'b0, cyc);
        check("fresh_cycles", 32'(cyc), 32'(2 + 4 * n));
        check_run("fresh", 1'b0);
        commit_words(n);
        check_mem("fresh_mem");

        // Address aliasing
        PC = 32'h0000_0102; #1;
        check("alias_low_bits", Instr, model_mem[0]);
        PC = 32'h0000_0100 + 32'(4 * DEPTH); #1;
        check("alias_wrap", Instr, model_mem[0]);
        for (int k = 0; k < 8; k++) begin
            pc_r = $urandom;
            PC = pc_r; #1;
            check("alias_rand", Instr, model_mem[(pc_r >> 2) % DEPTH]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
